vga_sync_decoder: RTL and testbench

Receive-side counterpart of the VGA timing generator. Samples the active-low VGA_HS/VGA_VS pair on pixel-enable strobes and rebuilds the generator's horizontal and vertical counters. Checks line and frame geometry against the 800×525 timing and exposes recovered pixel coordinates, an active-area flag and lock/error status. Used as an in-fabric loopback checker and as the coordinate source for overlay logic driven from the sync outputs only.

---
 rtl/vga_sync_decoder.sv | 164 ++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// Rebuilds VGA timing-generator counters from sampled HS/VS, verifies line/frame
// geometry, and reports recovered pixel coordinates plus lock/error status.
module vga_sync_decoder #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int H_SYNC_LEN  = 97,
    parameter int H_ACT_LO    = 145,
    parameter int H_ACT_HI    = 783,
    parameter int V_ACT_LO    = 35,
    parameter int V_ACT_HI    = 515,
    parameter int H_X_OFF     = 144,
    parameter int V_Y_OFF     = 35,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        CLOCK_50,
    input  logic        reset_n,
    input  logic        pix_en,
    input  logic        vga_hs,
    input  logic        vga_vs,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        active,
    output logic        locked,
    output logic        frame_start,
    output logic        err,
    output logic [1:0]  err_code
);
    localparam int CW = $clog2(LOCK_FRAMES + 1);
    localparam logic [11:0]   H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0]   V_LAST = 12'(V_TOTAL - 1);
    localparam logic [11:0]   H_SYNC = 12'(H_SYNC_LEN);
    localparam logic [11:0]   H_LO   = 12'(H_ACT_LO);
    localparam logic [11:0]   H_HI   = 12'(H_ACT_HI);
    localparam logic [11:0]   V_LO   = 12'(V_ACT_LO);
    localparam logic [11:0]   V_HI   = 12'(V_ACT_HI);
    localparam logic [11:0]   X_OFF  = 12'(H_X_OFF);
    localparam logic [11:0]   Y_OFF  = 12'(V_Y_OFF);
    localparam logic [CW-1:0] LOCK_N = CW'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    state_t        state, state_n;
    logic [CW-1:0] clean, clean_n;
    logic [11:0]   hcount, vcount, hs_low;
    logic [11:0]   hcount_n, vcount_n, hs_low_n;
    logic          hs_q, vs_q_line;
    logic          hfall, hrise, fs;
    logic          e_frame, e_line, e_hs, err_hit, active_n;
    logic [1:0]    code;

    // Counter reconstruction; all terms are only committed on a pix_en sample.
    always_comb begin
        hfall    = hs_q & ~vga_hs;
        hrise    = ~hs_q & vga_hs;
        fs       = hfall & ~vga_vs & vs_q_line;
        hcount_n = hfall ? 12'd0 : ((&hcount) ? hcount : hcount + 12'd1);
        vcount_n = vcount;
        if (hfall)
            vcount_n = fs ? 12'd0 : ((&vcount) ? vcount : vcount + 12'd1);
        hs_low_n = hs_low;
        if (hfall)
            hs_low_n = 12'd1;
        else if (!vga_hs && !(&hs_low))
            hs_low_n = hs_low + 12'd1;
    end

    always_comb begin
        e_frame = (state != SEARCH) & fs    & (vcount != V_LAST);
        e_line  = (state != SEARCH) & hfall & (hcount != H_LAST);
        e_hs    = (state != SEARCH) & hrise & (hs_low != H_SYNC);
        err_hit = pix_en & (e_frame | e_line | e_hs);
        code    = e_frame ? 2'd3 : (e_line ? 2'd1 : 2'd2);
    end

    always_comb begin
        state_n = state;
        clean_n = clean;
        if (pix_en) begin
            case (state)
                SEARCH: begin
                    if (fs) begin
                        state_n = MEASURE;
                        clean_n = '0;
                    end
                end
                MEASURE: begin
                    if (err_hit) begin
                        state_n = SEARCH;
                        clean_n = '0;
                    end else if (fs) begin
                        clean_n = clean + CW'(1);
                        if (clean_n == LOCK_N)
                            state_n = LOCKED;
                    end
                end
                LOCKED: begin
                    if (err_hit) begin
                        state_n = SEARCH;
                        clean_n = '0;
                    end
                end
                default: begin
                    state_n = SEARCH;
                    clean_n = '0;
                end
            endcase
        end
    end

    // Active window is judged on the post-update counters and post-update lock.
    assign active_n = (state_n == LOCKED) &
                      (hcount_n >= H_LO) & (hcount_n <= H_HI) &
                      (vcount_n >= V_LO) & (vcount_n <= V_HI);

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state <= SEARCH;
            clean <= '0;
        end else begin
            state <= state_n;
            clean <= clean_n;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            hcount    <= '0;
            vcount    <= '0;
            hs_low    <= '0;
            hs_q      <= 1'b1;
            vs_q_line <= 1'b1;
        end else if (pix_en) begin
            hcount <= hcount_n;
            vcount <= vcount_n;
            hs_low <= hs_low_n;
            hs_q   <= vga_hs;
            if (hfall)
                vs_q_line <= vga_vs;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            x           <= '0;
            y           <= '0;
            active      <= 1'b0;
            locked      <= 1'b0;
            frame_start <= 1'b0;
            err         <= 1'b0;
            err_code    <= 2'd0;
        end else begin
            frame_start <= pix_en & fs;
            err         <= err_hit;
            if (pix_en) begin
                locked <= (state_n == LOCKED);
                active <= active_n;
                x      <= active_n ? hcount_n - X_OFF : 12'd0;
                y      <= active_n ? vcount_n - Y_OFF : 12'd0;
                if (err_hit)
                    err_code <= code;
            end
        end
    end
endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a reduced 40x20 geometry so that many
// frames fit in a short run; the timing relationships are the same as 800x525.
module tb_vga_sync_decoder;
    localparam int H_TOTAL    = 40;
    localparam int V_TOTAL    = 20;
    localparam int H_SYNC_LEN = 5;
    localparam int V_SYNC_LEN = 2;

    logic        clk, reset_n, pix_en, vga_hs, vga_vs;
    logic [11:0] x, y;
    logic        active, locked, frame_start, err;
    logic [1:0]  err_code;

    vga_sync_decoder #(
        .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL), .H_SYNC_LEN(H_SYNC_LEN),
        .H_ACT_LO(9), .H_ACT_HI(35), .V_ACT_LO(4), .V_ACT_HI(17),
        .H_X_OFF(8), .V_Y_OFF(4), .LOCK_FRAMES(2)
    ) dut (
        .CLOCK_50(clk), .reset_n(reset_n), .pix_en(pix_en),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .x(x), .y(y), .active(active),
        .locked(locked), .frame_start(frame_start), .err(err), .err_code(err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int   v;
        int   h;
        logic act;
        int   ex;
        int   ey;
    } pt_t;
    pt_t tbl[8];

    int n_vec, n_bad;
    int gap_max, glitch;
    int cur_v, cur_h;
    int err_cnt, last_code, err_locked, err_v, err_h;
    int fs_since, lock_seen, lock_fs, lock_on_fs, prev_locked;
    int pulse_bad, hold_bad;
    int hold_x, hold_y, hold_act, hold_lock, hold_code;

    task automatic chk(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ":x"}, int'(x), 0);
        chk({tag, ":y"}, int'(y), 0);
        chk({tag, ":active"}, int'(active), 0);
        chk({tag, ":locked"}, int'(locked), 0);
        chk({tag, ":frame_start"}, int'(frame_start), 0);
        chk({tag, ":err"}, int'(err), 0);
        chk({tag, ":err_code"}, int'(err_code), 0);
    endtask

    task automatic clear_track();
        fs_since = 0; lock_seen = 0; prev_locked = 0; err_cnt = 0;
        hold_x = 0; hold_y = 0; hold_act = 0; hold_lock = 0; hold_code = 0;
    endtask

    // Idle gap cycles (optionally with sync glitches), then one pix_en sample.
    task automatic strobe(input logic hs, input logic vs);
        int g;
        g = (gap_max > 1) ? int'($urandom_range(gap_max, 1)) : gap_max;
        for (int i = 0; i < g; i++) begin
            @(negedge clk);
            pix_en = 1'b0;
            if (glitch != 0) begin
                vga_hs = 1'($urandom_range(1, 0));
                vga_vs = 1'($urandom_range(1, 0));
            end
            @(posedge clk); #1;
            if (frame_start || err) pulse_bad++;
            if (int'(x) != hold_x || int'(y) != hold_y || int'(active) != hold_act ||
                int'(locked) != hold_lock || int'(err_code) != hold_code) hold_bad++;
        end
        @(negedge clk);
        pix_en = 1'b1; vga_hs = hs; vga_vs = vs;
        @(posedge clk); #1;
        pix_en = 1'b0;
        hold_x = int'(x); hold_y = int'(y); hold_act = int'(active);
        hold_lock = int'(locked); hold_code = int'(err_code);
        if (err) begin
            err_cnt++; last_code = int'(err_code); err_locked = int'(locked);
            err_v = cur_v; err_h = cur_h; fs_since = 0;
        end else if (frame_start) begin
            fs_since++;
        end
        if (locked && prev_locked == 0) begin
            lock_seen = 1; lock_fs = fs_since; lock_on_fs = int'(frame_start);
        end
        prev_locked = int'(locked);
    endtask

    task automatic check_table(input int v, input int h);
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].v == v && tbl[i].h == h) begin
                chk($sformatf("active@v%0d,h%0d", v, h), int'(active), int'(tbl[i].act));
                chk($sformatf("x@v%0d,h%0d", v, h), int'(x), tbl[i].ex);
                chk($sformatf("y@v%0d,h%0d", v, h), int'(y), tbl[i].ey);
            end
        end
    endtask

    task automatic send_line(input int v, input int h0, input int h1, input int hsw, input bit use_tbl);
        for (int h = h0; h < h1; h++) begin
            cur_v = v; cur_h = h;
            strobe(h >= hsw, v >= V_SYNC_LEN);
            if (use_tbl) check_table(v, h);
        end
    endtask

    task automatic send_frame(input int nlines, input int short_v, input int narrow_v, input bit use_tbl);
        int len, hsw;
        for (int v = 0; v < nlines; v++) begin
            len = (v == short_v) ? H_TOTAL - 1 : H_TOTAL;
            hsw = (v == narrow_v) ? H_SYNC_LEN - 1 : H_SYNC_LEN;
            send_line(v, 0, len, hsw, use_tbl);
        end
    endtask

    initial begin
        #1_200_000;
        $display("FAIL watchdog: run did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{v: 0,  h: 0,  act: 1'b0, ex: 0,  ey: 0};
        tbl[1] = '{v: 4,  h: 9,  act: 1'b1, ex: 1,  ey: 0};
        tbl[2] = '{v: 4,  h: 8,  act: 1'b0, ex: 0,  ey: 0};
        tbl[3] = '{v: 3,  h: 9,  act: 1'b0, ex: 0,  ey: 0};
        tbl[4] = '{v: 10, h: 20, act: 1'b1, ex: 12, ey: 6};
        tbl[5] = '{v: 17, h: 35, act: 1'b1, ex: 27, ey: 13};
        tbl[6] = '{v: 17, h: 36, act: 1'b0, ex: 0,  ey: 0};
        tbl[7] = '{v: 18, h: 9,  act: 1'b0, ex: 0,  ey: 0};
        n_vec = 0; n_bad = 0; pulse_bad = 0; hold_bad = 0;
        gap_max = 1; glitch = 0; last_code = 0; err_locked = 0;
        err_v = -1; err_h = -1; lock_fs = 0; lock_on_fs = 0;
        cur_v = 0; cur_h = 0;
        clear_track();

        reset_n = 1'b0; pix_en = 1'b0; vga_hs = 1'b1; vga_vs = 1'b1;
        #3;
        chk_zero("reset");
        repeat (3) @(posedge clk);
        @(negedge clk); reset_n = 1'b1;

        // Nominal lock: third frame start raises locked.
        send_frame(V_TOTAL, -1, -1, 0);
        send_frame(V_TOTAL, -1, -1, 0);
        chk("nom:locked_before_3rd_fs", int'(locked), 0);
        send_frame(V_TOTAL, -1, -1, 1);
        chk("nom:lock_seen", lock_seen, 1);
        chk("nom:lock_fs_count", lock_fs, 3);
        chk("nom:lock_with_frame_start", lock_on_fs, 1);
        chk("nom:err_count", err_cnt, 0);

        // Short line (39 samples on line 7): error surfaces at line 8 fall.
        err_cnt = 0; lock_seen = 0;
        send_frame(V_TOTAL, 7, -1, 0);
        chk("short:err_count", err_cnt, 1);
        chk("short:err_code", last_code, 1);
        chk("short:locked_at_err", err_locked, 0);
        chk("short:err_line", err_v, 8);
        chk("short:err_pixel", err_h, 0);
        send_frame(V_TOTAL, -1, -1, 0);
        send_frame(V_TOTAL, -1, -1, 0);
        chk("short:not_relocked_early", lock_seen, 0);
        send_frame(V_TOTAL, -1, -1, 0);
        chk("short:relock_fs_count", lock_fs, 3);

        // HS low for one sample too few on line 5.
        err_cnt = 0; lock_seen = 0;
        send_frame(V_TOTAL, -1, 5, 0);
        chk("hsw:err_count", err_cnt, 1);
        chk("hsw:err_code", last_code, 2);
        chk("hsw:locked_at_err", err_locked, 0);
        chk("hsw:err_pixel", err_h, H_SYNC_LEN - 1);
        chk("hsw:state_search", int'(locked), 0);
        send_frame(V_TOTAL, -1, -1, 0);
        send_frame(V_TOTAL, -1, -1, 0);
        send_frame(V_TOTAL, -1, -1, 0);
        chk("hsw:relock_fs_count", lock_fs, 3);

        // Frame one line short: error on the next frame start.
        err_cnt = 0; lock_seen = 0;
        send_frame(V_TOTAL - 1, -1, -1, 0);
        chk("flen:no_err_yet", err_cnt, 0);
        send_frame(V_TOTAL, -1, -1, 0);
        chk("flen:err_count", err_cnt, 1);
        chk("flen:err_code", last_code, 3);
        chk("flen:err_at_frame_start", err_v * 1000 + err_h, 0);
        chk("flen:locked_at_err", err_locked, 0);
        chk("flen:err_code_holds", int'(err_code), 3);
        send_frame(V_TOTAL, -1, -1, 0);
        send_frame(V_TOTAL, -1, -1, 0);
        send_frame(V_TOTAL, -1, -1, 0);
        chk("flen:relock_fs_count", lock_fs, 3);

        // Strobe gating with 1..5 idle cycles and sync glitches in the gaps.
        @(negedge clk); reset_n = 1'b0;
        #1;
        chk("gate:reset_err_code", int'(err_code), 0);
        @(negedge clk); reset_n = 1'b1;
        clear_track();
        gap_max = 5; glitch = 1;
        send_frame(V_TOTAL, -1, -1, 0);
        send_frame(V_TOTAL, -1, -1, 0);
        chk("gate:locked_before_3rd_fs", int'(locked), 0);
        send_frame(V_TOTAL, -1, -1, 1);
        chk("gate:lock_fs_count", lock_fs, 3);
        chk("gate:lock_with_frame_start", lock_on_fs, 1);
        chk("gate:err_count", err_cnt, 0);
        gap_max = 1; glitch = 0;

        // Asynchronous reset in the middle of an active line.
        send_frame(10, -1, -1, 0);
        send_line(10, 0, 16, H_SYNC_LEN, 0);
        chk("midrst:active_before", int'(active), 1);
        #2 reset_n = 1'b0;
        #1 chk_zero("midrst");
        #1 reset_n = 1'b1;
        clear_track();
        send_line(10, 16, H_TOTAL, H_SYNC_LEN, 0);
        for (int v = 11; v < V_TOTAL; v++) send_line(v, 0, H_TOTAL, H_SYNC_LEN, 0);
        send_frame(V_TOTAL, -1, -1, 0);
        send_frame(V_TOTAL, -1, -1, 0);
        chk("midrst:not_relocked_early", lock_seen, 0);
        send_frame(V_TOTAL, -1, -1, 0);
        chk("midrst:relock_fs_count", lock_fs, 3);
        chk("midrst:err_count", err_cnt, 0);

        chk("pulse_width_single_cycle", pulse_bad, 0);
        chk("outputs_hold_between_strobes", hold_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
